// File: rtl/mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough to hold the iteration count DATAWIDTH itself.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: operand magnitudes, accumulator/multiplier shift pair, final sign fix-up.
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_fin,
  input  logic                 i_sgn,
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_b,
  output logic [DATAWIDTH-1:0] o_lo,
  output logic [DATAWIDTH-1:0] o_hi
);

  localparam int W = DATAWIDTH;

  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_acc;
  logic           r_neg;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_full;
  logic [2*W-1:0] w_full_neg;

  // The most-negative operand maps to 2^(W-1), which still fits as unsigned.
  assign w_a_mag    = (i_sgn && i_a[W-1]) ? (~i_a + 1'b1) : i_a;
  assign w_b_mag    = (i_sgn && i_b[W-1]) ? (~i_b + 1'b1) : i_b;
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_mcand & {W{r_mplier[0]}}};
  assign w_full     = {r_acc, r_mplier};
  assign w_full_neg = ~w_full + 1'b1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_neg    <= i_sgn & (i_a[W-1] ^ i_b[W-1]);
    end else if (i_step) begin
      r_acc    <= w_sum[W:1];
      r_mplier <= {w_sum[0], r_mplier[W-1:1]};
    end else if (i_fin && r_neg) begin
      {r_acc, r_mplier} <= w_full_neg;
    end
  end

  assign o_lo = r_mplier;
  assign o_hi = r_acc;

endmodule

// File: rtl/mul_seq.sv
// Iterative radix-2 multiplier with valid/ready on both sides.
// Define MUL_OVF_EN to add the ovf port and saturate the low half on overflow.
module mul_seq
  import mul_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] prod,
  output logic [DATAWIDTH-1:0] prod_hi
`ifdef MUL_OVF_EN
  ,
  output logic                 ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high once out of reset
  // CALC  | DATAWIDTH shift-add steps, then one cycle applying the sign
  // DONE  | result held until out_ready

  localparam int             CW       = cnt_width(DATAWIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATAWIDTH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_live;
  logic            w_load;
  logic            w_step;
  logic            w_fin;
  logic [DATAWIDTH-1:0] w_lo;
  logic [DATAWIDTH-1:0] w_hi;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && r_live) begin
          w_state_nxt = CALC;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_step      = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = r_live && (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  mul_shift_add_dp #(
    .DATAWIDTH(DATAWIDTH)
  ) u_dp (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_load(w_load),
    .i_step(w_step),
    .i_fin (w_fin),
    .i_sgn (sgn),
    .i_a   (a),
    .i_b   (b),
    .o_lo  (w_lo),
    .o_hi  (w_hi)
  );

  assign prod_hi = w_hi;

`ifdef MUL_OVF_EN
  logic                 r_sgn;
  logic                 w_ovf_raw;
  logic [DATAWIDTH-1:0] w_sat;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)        r_sgn <= 1'b0;
    else if (w_load) r_sgn <= sgn;
  end

  // Signed fit means the high half is pure sign extension of the low half.
  assign w_ovf_raw = r_sgn ? (w_hi != {DATAWIDTH{w_lo[DATAWIDTH-1]}}) : (w_hi != '0);
  assign w_sat     = !r_sgn ? {DATAWIDTH{1'b1}} :
                     w_hi[DATAWIDTH-1] ? {1'b1, {(DATAWIDTH-1){1'b0}}} :
                                         {1'b0, {(DATAWIDTH-1){1'b1}}};
  assign ovf       = out_valid && w_ovf_raw;
  assign prod      = ovf ? w_sat : w_lo;
`else
  assign prod      = w_lo;
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: 8-bit directed vectors and corner sequences, 64-bit randomized ops vs arithmetic model.
module tb_mul_seq;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8;
  logic [7:0]  prod8, prod_hi8;

  logic        in_valid64 = 1'b0, out_ready64 = 1'b0, sgn64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        in_ready64, out_valid64;
  logic [63:0] prod64, prod_hi64;

`ifdef MUL_OVF_EN
  logic        ovf8, ovf64;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_ovf_ops = 0;

  always #5 Clk = ~Clk;

  mul_seq #(.DATAWIDTH(8)) u_dut8 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8),
    .prod(prod8), .prod_hi(prod_hi8)
`ifdef MUL_OVF_EN
    , .ovf(ovf8)
`endif
  );

  mul_seq #(.DATAWIDTH(64)) u_dut64 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .sgn(sgn64), .out_valid(out_valid64), .out_ready(out_ready64),
    .prod(prod64), .prod_hi(prod_hi64)
`ifdef MUL_OVF_EN
    , .ovf(ovf64)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: true integer product of the operands read per sgn, reduced to 2w bits.
  function automatic void ref_mul(input int w, input logic [63:0] ia, input logic [63:0] ib,
                                  input logic is, output logic [63:0] lo, output logic [63:0] hi,
                                  output logic ov);
    logic [127:0] mask, ea, eb, p, half, full_mask;
    mask      = (128'd1 << w) - 128'd1;
    full_mask = (128'd1 << (2 * w)) - 128'd1;
    half      = 128'd1 << (w - 1);
    ea = {64'd0, ia} & mask;
    eb = {64'd0, ib} & mask;
    if (is && ea[w-1]) ea = ea | ~mask;
    if (is && eb[w-1]) eb = eb | ~mask;
    p  = ea * eb;
    lo = 64'(p & mask);
    hi = 64'((p >> w) & mask);
    if (is) ov = ((p + half) & full_mask) >= (128'd1 << w);
    else    ov = ((p & full_mask) >> w) != 128'd0;
`ifdef MUL_OVF_EN
    if (ov) begin
      if (!is)            lo = 64'(mask);
      else if (p[2*w-1])  lo = 64'(half);
      else                lo = 64'(half - 128'd1);
    end
`endif
  endfunction

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                     output logic [7:0] lo, output logic [7:0] hi, output logic ov,
                     output int lat);
    int g;
    bit busy_rdy;
    @(negedge Clk);
    a8 = ia; b8 = ib; sgn8 = is; in_valid8 = 1'b1;
    g = 0;
    while (!in_ready8 && g < 50) begin @(negedge Clk); g++; end
    chk("accept8", in_ready8, 1);
    @(posedge Clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    busy_rdy = 0;
    while (!out_valid8 && lat < 50) begin
      if (in_ready8) busy_rdy = 1;
      @(posedge Clk); #1;
      lat++;
    end
    chk("rdy_low_busy8", busy_rdy, 0);
    lo = prod8;
    hi = prod_hi8;
`ifdef MUL_OVF_EN
    ov = ovf8;
`else
    ov = 1'b0;
`endif
    out_ready8 = 1'b1;
    @(posedge Clk); #1;
    out_ready8 = 1'b0;
    chk("oval_clr8", out_valid8, 0);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       s;
    logic [7:0] hi, lo_raw;
    logic       ov;
    logic [7:0] lo_sat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0]  lo, hi;
    logic        ov;
    int          lat, g;
    logic [63:0] elo, ehi, ra, rb;
    logic        eov, rs;
    logic [7:0]  exp_lo;

    vecs[0]  = '{8'h07, 8'h06, 1'b0, 8'h00, 8'h2A, 1'b0, 8'h2A};
    vecs[1]  = '{8'hFD, 8'h05, 1'b1, 8'hFF, 8'hF1, 1'b0, 8'hF1};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 8'h40, 8'h00, 1'b1, 8'h7F};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, 1'b1, 8'hFF};
    vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 8'h00, 8'h01, 1'b0, 8'h01};
    vecs[5]  = '{8'h00, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[6]  = '{8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80, 1'b1, 8'h80};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 8'h3F, 8'h01, 1'b1, 8'h7F};
    vecs[8]  = '{8'hFF, 8'h01, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFF};
    vecs[9]  = '{8'h80, 8'h01, 1'b1, 8'hFF, 8'h80, 1'b0, 8'h80};
    vecs[10] = '{8'h10, 8'h10, 1'b0, 8'h01, 8'h00, 1'b1, 8'hFF};

    // Reset state
    #2 Rst = 1'b0;
    #2;
    chk("rst_out8", {in_ready8, out_valid8, prod_hi8, prod8}, 0);
    chk("rst_out64", {in_ready64, out_valid64, prod_hi64, prod64}, 0);
`ifdef MUL_OVF_EN
    chk("rst_ovf", {ovf8, ovf64}, 0);
`endif
    repeat (2) @(posedge Clk);
    #1 chk("rdy_in_rst", in_ready8, 0);
    @(negedge Clk) Rst = 1'b1;
    #1 chk("rdy_before_edge", in_ready8, 0);
    @(posedge Clk); #1;
    chk("rdy_after_edge", {in_ready8, in_ready64}, 2'b11);

    // Directed vectors
    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].s, lo, hi, ov, lat);
`ifdef MUL_OVF_EN
      exp_lo = vecs[i].ov ? vecs[i].lo_sat : vecs[i].lo_raw;
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
`else
      exp_lo = vecs[i].lo_raw;
      chk($sformatf("vec%0d_ovf", i), ov, 0);
`endif
      chk($sformatf("vec%0d_prod", i), {hi, lo}, {vecs[i].hi, exp_lo});
      chk($sformatf("vec%0d_lat", i), lat, 9);
    end

    // Stall in DONE with a new in_valid pending
    @(negedge Clk);
    a8 = 8'd7; b8 = 8'd6; sgn8 = 1'b0; in_valid8 = 1'b1;
    g = 0;
    while (!in_ready8 && g < 50) begin @(negedge Clk); g++; end
    @(posedge Clk); #1;
    a8 = 8'd3; b8 = 8'd3;
    g = 0;
    while (!out_valid8 && g < 50) begin @(posedge Clk); #1; g++; end
    chk("stall_reach_done", out_valid8, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("stall_hold%0d", k), {out_valid8, in_ready8, prod_hi8, prod8},
          {1'b1, 1'b0, 8'h00, 8'h2A});
    end
    out_ready8 = 1'b1;
    @(posedge Clk); #1;
    out_ready8 = 1'b0;
    chk("stall_release_idle", {out_valid8, in_ready8}, 2'b01);
    @(posedge Clk); #1;
    in_valid8 = 1'b0;
    chk("stall_accepted", in_ready8, 0);
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(posedge Clk); #1; lat++; end
    chk("stall_next_lat", lat, 9);
    chk("stall_next_prod", {prod_hi8, prod8}, 16'h0009);
    out_ready8 = 1'b1;
    @(posedge Clk); #1;
    out_ready8 = 1'b0;

    // Reset mid-CALC
    @(negedge Clk);
    a8 = 8'd7; b8 = 8'd6; sgn8 = 1'b0; in_valid8 = 1'b1;
    g = 0;
    while (!in_ready8 && g < 50) begin @(negedge Clk); g++; end
    @(posedge Clk); #1;
    in_valid8 = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Rst = 1'b0;
    #1 chk("midrst_clear", {out_valid8, in_ready8, prod_hi8, prod8}, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b1;
    repeat (12) begin
      @(posedge Clk); #1;
      if (out_valid8) break;
    end
    chk("midrst_no_result", out_valid8, 0);
    op8(8'd3, 8'd3, 1'b0, lo, hi, ov, lat);
    chk("midrst_fresh_prod", {hi, lo}, 16'h0009);
    chk("midrst_fresh_lat", lat, 9);

    // 64-bit randomized, in_valid held high throughout
    out_ready64 = 1'b1;
    @(posedge Clk); #1;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 64'h8000_0000_0000_0000;
        1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        2: ra = 64'd0;
        3: rb = 64'h7FFF_FFFF_FFFF_FFFF;
        4: ra = 64'(ra[15:0]);
        default: ;
      endcase
      a64 = ra; b64 = rb; sgn64 = rs; in_valid64 = 1'b1;
      g = 0;
      while (!in_ready64 && g < 300) begin @(posedge Clk); #1; g++; end
      if (!in_ready64) chk("accept64", in_ready64, 1);
      @(posedge Clk); #1;
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      sgn64 = ~rs;
      ref_mul(64, ra, rb, rs, elo, ehi, eov);
      if (eov) n_ovf_ops++;
      lat = 0;
      while (!out_valid64 && lat < 200) begin @(posedge Clk); #1; lat++; end
      chk($sformatf("rnd%0d_lat", i), lat, 65);
      chk($sformatf("rnd%0d_prod", i), {prod_hi64, prod64}, {ehi, elo});
`ifdef MUL_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), ovf64, eov);
`endif
    end
    in_valid64 = 1'b0;
    @(posedge Clk); #1;
    chk("rnd_end_clr", out_valid64, 0);

    $display("info: 64-bit ops outside single-width range: %0d", n_ovf_ops);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
